// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: 2-flop sync, debounce, press/release pulses, auto-repeat.
// Latency: 2+DB_CYCLES edges from a clean pad edge to level and its press/release pulse.
// No backpressure: pulses are one-cycle events and are dropped (not deferred) while pause=1.
module btn_conditioner #(
    parameter int             NCH           = 5,
    parameter int             DB_CYCLES     = 500000,
    parameter int             REPEAT_DELAY  = 20000000,
    parameter int             REPEAT_PERIOD = 5000000,
    parameter logic [NCH-1:0] REPEAT_MASK   = 5'b01110
) (
    input  logic           clk,
    input  logic           sw_rst,
    input  logic           pause,
    input  logic [NCH-1:0] btn_in,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] press,
    output logic [NCH-1:0] released
);

    localparam int DB_RD   = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (DB_RD > REPEAT_PERIOD) ? DB_RD : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [CW-1:0]  db_cnt   [NCH];
    logic [CW-1:0]  rc       [NCH];
    rep_state_t     rep_state[NCH];

    logic [NCH-1:0] db_hit;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] rep_fire;

    // Decode the events that the next edge will commit, from registered state only.
    always_comb begin
        db_hit   = '0;
        rise     = '0;
        fall     = '0;
        rep_fire = '0;
        for (int i = 0; i < NCH; i++) begin
            db_hit[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
            rise[i]   = db_hit[i] && !level[i];
            fall[i]   = db_hit[i] && level[i];
            // A repeat landing on the release edge is swallowed so only the release is seen.
            if (REPEAT_MASK[i] && !pause && !fall[i]) begin
                case (rep_state[i])
                    DELAY:   rep_fire[i] = (rc[i] == RD_LAST);
                    REPEAT:  rep_fire[i] = (rc[i] == RP_LAST);
                    default: rep_fire[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge sw_rst) begin
        if (!sw_rst) begin
            sync1    <= '0;
            sync2    <= '0;
            level    <= '0;
            press    <= '0;
            released <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i]    <= '0;
                rc[i]        <= '0;
                rep_state[i] <= IDLE;
            end
        end else begin
            sync1    <= btn_in;
            sync2    <= sync1;
            press    <= pause ? '0 : (rise | rep_fire);
            released <= pause ? '0 : fall;

            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_hit[i]) begin
                        level[i]  <= ~level[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end

                // Pause parks the FSM in IDLE; only a fresh rise can re-arm it afterwards.
                if (!REPEAT_MASK[i] || pause || fall[i]) begin
                    rep_state[i] <= IDLE;
                    rc[i]        <= '0;
                end else begin
                    case (rep_state[i])
                        IDLE: begin
                            rc[i] <= '0;
                            if (rise[i]) rep_state[i] <= DELAY;
                        end
                        DELAY: begin
                            if (rc[i] == RD_LAST) begin
                                rc[i]        <= '0;
                                rep_state[i] <= REPEAT;
                            end else begin
                                rc[i] <= rc[i] + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rc[i] == RP_LAST) rc[i] <= '0;
                            else                  rc[i] <= rc[i] + 1'b1;
                        end
                        default: begin
                            rep_state[i] <= IDLE;
                            rc[i]        <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings.
module tb_btn_conditioner;

    localparam int NCH = 5;

    logic           clk;
    logic           sw_rst;
    logic           pause;
    logic [NCH-1:0] btn_in;
    logic [NCH-1:0] level;
    logic [NCH-1:0] press;
    logic [NCH-1:0] released;

    int n_checks = 0;
    int n_errors = 0;

    btn_conditioner #(
        .NCH          (NCH),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3),
        .REPEAT_MASK  (5'b01110)
    ) dut (
        .clk     (clk),
        .sw_rst  (sw_rst),
        .pause   (pause),
        .btn_in  (btn_in),
        .level   (level),
        .press   (press),
        .released(released)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input int e, input logic [NCH-1:0] obs,
                       input logic [NCH-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic chk_all(input string tname, input int e, input logic [NCH-1:0] e_lvl,
                           input logic [NCH-1:0] e_prs, input logic [NCH-1:0] e_rel);
        chk({tname, ".level"}, e, level, e_lvl);
        chk({tname, ".press"}, e, press, e_prs);
        chk({tname, ".release"}, e, released, e_rel);
    endtask

    initial begin
        logic [NCH-1:0] el, ep, er;

        sw_rst = 1'b1;
        pause  = 1'b0;
        btn_in = '0;
        #1 sw_rst = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, '0, '0, '0);
        sw_rst = 1'b1;

        // 1: channel 1 held, repeats at 16/19/22, dropped so level falls at edge 24
        btn_in = 5'b00010;
        for (int e = 1; e <= 28; e++) begin
            if (e == 19) btn_in = '0;
            tick();
            el = (e >= 6 && e < 24) ? 5'b00010 : 5'b00000;
            ep = (e == 6 || e == 16 || e == 19 || e == 22) ? 5'b00010 : 5'b00000;
            er = (e == 24) ? 5'b00010 : 5'b00000;
            chk_all("t1", e, el, ep, er);
        end
        repeat (6) tick();

        // 2: 3-cycle glitch, then per-cycle toggling, never accepted
        for (int e = 1; e <= 40; e++) begin
            if (e <= 3)                btn_in = 5'b00100;
            else if (e >= 8 && e < 28) btn_in = e[0] ? 5'b00100 : 5'b00000;
            else                       btn_in = '0;
            tick();
            chk_all("t2", e, '0, '0, '0);
        end
        repeat (6) tick();

        // 3: non-repeat channel 0 held 40 cycles
        for (int e = 1; e <= 50; e++) begin
            btn_in = (e <= 40) ? 5'b00001 : 5'b00000;
            tick();
            el = (e >= 6 && e < 46) ? 5'b00001 : 5'b00000;
            ep = (e == 6)  ? 5'b00001 : 5'b00000;
            er = (e == 46) ? 5'b00001 : 5'b00000;
            chk_all("t3", e, el, ep, er);
        end
        repeat (6) tick();

        // 4: channel 3 with pause over 8..30, then release/re-press; repeat on the release edge is suppressed
        for (int e = 1; e <= 90; e++) begin
            btn_in = ((e <= 50) || (e >= 61 && e <= 79)) ? 5'b01000 : 5'b00000;
            pause  = (e >= 8 && e <= 30);
            tick();
            el = ((e >= 6 && e < 56) || (e >= 66 && e < 85)) ? 5'b01000 : 5'b00000;
            ep = (e == 6 || e == 66 || e == 76 || e == 79 || e == 82) ? 5'b01000 : 5'b00000;
            er = (e == 56 || e == 85) ? 5'b01000 : 5'b00000;
            chk_all("t4", e, el, ep, er);
        end
        pause = 1'b0;
        repeat (6) tick();

        // 5: channels 1 and 4 held, async reset mid-hold, fresh press after release
        btn_in = 5'b10010;
        for (int e = 1; e <= 24; e++) begin
            if (e == 12) begin
                #1 sw_rst = 1'b0;
                #1;
                chk_all("t5.async", e, '0, '0, '0);
            end
            if (e == 14) sw_rst = 1'b1;
            tick();
            el = ((e >= 6 && e <= 11) || e >= 19) ? 5'b10010 : 5'b00000;
            ep = (e == 6 || e == 19) ? 5'b10010 : 5'b00000;
            chk_all("t5", e, el, ep, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Parametrised multi-channel front end for the game's push-buttons (drop, rotate, left, right, down).
- Per channel: synchronises the raw pad, debounces it, and emits one-cycle press and release pulses.
- Channels selected in REPEAT_MASK also auto-repeat while held (delayed auto-shift).
- Sits between the board buttons and the game-control FSM. A pause input suppresses all events.

Parameters:
- NCH, 5, number of button channels.
- DB_CYCLES, 500000, consecutive disagreeing cycles required to accept a level change (5 ms at 100 MHz); must be ≥2.
- REPEAT_DELAY, 20000000, cycles from accepted press to first repeat pulse; must be ≥2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; must be ≥2.
- REPEAT_MASK, 5'b01110, bit i=1 enables auto-repeat on channel i.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- sw_rst  input  1  asynchronous, active-low reset.
- pause  input  1  synchronous; 1 = suppress press/release/repeat events.
- btn_in  input  NCH  raw asynchronous button levels, active-high.
- level  output  NCH  debounced button level.
- press  output  NCH  one-cycle pulse on accepted press and on each auto-repeat.
- release  output  NCH  one-cycle pulse on accepted release.

Behaviour:
- Reset (sw_rst=0, asynchronous):
  - level, press and release = 0.
  - Synchroniser flops, debounce counters and repeat counters = 0.
  - All repeat FSMs = IDLE.
  - A reset asserted mid-hold discards all state. After release of reset, a still-held button is re-debounced from zero and produces a fresh press.
- Synchroniser: two flops per channel; the output is sync[i].
- Debounce, per channel, each edge:
  - If sync[i] ≠ level[i]: when cnt = DB_CYCLES−1, level[i] toggles and cnt clears; otherwise cnt increments.
  - If sync[i] = level[i]: cnt clears.
  - Any bounce shorter than DB_CYCLES restarts the count.
  - Latency from a clean btn_in edge to the level change: 2+DB_CYCLES edges.
- Counter width: $clog2 of max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD). Counters never wrap; they always clear at their terminal value.
- press and release are registered and valid in the same cycle as the level change.
  - press[i]=1 for exactly one cycle on a 0→1 level change.
  - release[i]=1 for exactly one cycle on a 1→0 level change.
  - Both are forced to 0 while pause=1.
- Repeat FSM, per channel with REPEAT_MASK[i]=1; states IDLE, DELAY, REPEAT, with its own counter rc:
  - IDLE → DELAY on a level rise while pause=0; rc=0.
  - DELAY: rc increments each edge. When rc = REPEAT_DELAY−1: press pulse, rc=0, go to REPEAT. The first repeat is therefore visible REPEAT_DELAY edges after the initial press.
  - REPEAT: when rc = REPEAT_PERIOD−1: press pulse, rc=0, stay in REPEAT.
  - Level fall: go to IDLE from any state, rc=0. A repeat pulse that coincides with the release edge is suppressed; only release pulses.
  - pause=1: FSM forced to IDLE, rc=0. On pause deassert with the button still held, no press and no repeat until the button is released and pressed again.
- Channels with REPEAT_MASK[i]=0: the FSM is absent or stays IDLE; one press per accepted press, nothing more.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- No combinational path from btn_in or pause to any output.

Test Plan (NCH=5, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=5'b01110):
1. Reset, then btn_in[1] rises cleanly before edge 1 and is held:
   - level[1] and press[1] go high after edge 6.
   - Repeat press pulses after edges 16, 19, 22.
   - Drop the button so the level falls after edge 24: release[1] pulses then, with no press in that cycle.
2. btn_in[2] glitches high for 3 cycles, then low; also toggle every cycle for 20 cycles -> level, press and release stay 0 throughout.
3. btn_in[0] (no repeat) held 40 cycles -> exactly one press[0] (after edge 6) and one release[0] (6 edges after the drop).
4. Hold btn_in[3]. Assert pause for edges 8–30, then deassert while still held:
   - press[3] pulses after edge 6.
   - No pulses during pause, and none after deassert.
   - Release and re-press -> a new press and a new repeat sequence.
5. Hold btn_in[1] and btn_in[4] simultaneously; pull sw_rst low at edge 12 for 2 cycles:
   - All outputs go to 0 immediately.
   - After reset release, press pulses again 6 edges later on both channels in the same cycle.
